// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch program counter.
package pc_gen_pkg;

  localparam logic        RstEnable         = 1'b1;
  localparam logic        ChipEnable        = 1'b1;
  localparam logic        ChipDisable       = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // Source of the next pc, in decreasing priority.
  typedef enum logic [2:0] {
    SelFlush,
    SelHold,
    SelBranch,
    SelPend,
    SelSeq
  } pc_sel_e;

endpackage

// File: rtl/pc_redirect_hold.sv
// Buffers a branch that arrives while fetch is stalled until the stall releases.
module pc_redirect_hold
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_target,
  output logic              pend,
  output logic [ADDR_W-1:0] pend_target
);

  // Reset wins, then load (a later stalled branch overwrites), then clear.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pend        <= 1'b0;
      pend_target <= ADDR_W'(ZeroWord);
    end else if (load) begin
      pend        <= 1'b1;
      pend_target <= load_target;
    end else if (clear) begin
      pend        <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: sequential increment, stall, branch and flush redirect.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
  parameter int unsigned       INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_pend,
  output logic              pc_misalign
);

  localparam logic [ADDR_W-1:0] IncBytes  = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pend_target;
  logic              hold_load;
  logic              hold_clear;

  // Strict priority: flush > stall > live branch > buffered branch > increment.
  always_comb begin
    sel = SelSeq;
    if (flush) begin
      sel = SelFlush;
    end else if (stall) begin
      sel = SelHold;
    end else if (branch_flag) begin
      sel = SelBranch;
    end else if (redirect_pend) begin
      sel = SelPend;
    end
  end

  // Next-pc mux; increment wraps naturally modulo 2^ADDR_W.
  always_comb begin
    pc_next = pc + IncBytes;
    unique case (sel)
      SelFlush:  pc_next = flush_target;
      SelHold:   pc_next = pc;
      SelBranch: pc_next = branch_target;
      SelPend:   pc_next = pend_target;
      SelSeq:    pc_next = pc + IncBytes;
      default:   pc_next = pc + IncBytes;
    endcase
  end

  // Buffer control is only active once fetch is enabled.
  always_comb begin
    hold_load  = ce && (sel == SelHold) && branch_flag;
    hold_clear = ce && (sel inside {SelFlush, SelBranch, SelPend});
  end

  pc_redirect_hold #(
    .ADDR_W (ADDR_W)
  ) u_redirect_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (hold_load),
    .clear       (hold_clear),
    .load_target (branch_target),
    .pend        (redirect_pend),
    .pend_target (pend_target)
  );

  // First cycle out of reset only raises ce, so RESET_VEC is fetched for a full cycle.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ce <= ChipDisable;
      pc <= RESET_VEC;
    end else if (ce == ChipDisable) begin
      ce <= ChipEnable;
    end else begin
      pc <= pc_next;
    end
  end

  // Targets are loaded unaligned; flag it while the fetch address is misaligned.
  always_comb begin
    pc_misalign = (ce == ChipEnable) && (|(pc & AlignMask));
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues expected outputs, monitor checks them.
module tb_pc_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst = 1'b1, stall = 1'b0, bf = 1'b0, fl = 1'b0;
  logic [31:0] bt = '0, ft = '0;
  logic [31:0] pc;
  logic        ce, pend, mis;

  // 8-bit instance for wrap-around
  logic        rst8 = 1'b1, stall8 = 1'b0, bf8 = 1'b0, fl8 = 1'b0;
  logic [7:0]  bt8 = '0, ft8 = '0;
  logic [7:0]  pc8;
  logic        ce8, pend8, mis8;

  pc_gen u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (bf),
    .branch_target (bt),
    .flush         (fl),
    .flush_target  (ft),
    .pc            (pc),
    .ce            (ce),
    .redirect_pend (pend),
    .pc_misalign   (mis)
  );

  pc_gen #(
    .ADDR_W     (8),
    .RESET_VEC  (8'hF0),
    .INST_BYTES (4)
  ) u_dut8 (
    .clk           (clk),
    .rst           (rst8),
    .stall         (stall8),
    .branch_flag   (bf8),
    .branch_target (bt8),
    .flush         (fl8),
    .flush_target  (ft8),
    .pc            (pc8),
    .ce            (ce8),
    .redirect_pend (pend8),
    .pc_misalign   (mis8)
  );

  typedef struct {
    bit          is8;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: every posedge with an outstanding expectation, compare outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is8) begin
          check(e.name, "pc",   {24'h0, pc8}, e.pc);
          check(e.name, "ce",   {31'h0, ce8}, {31'h0, e.ce});
          check(e.name, "pend", {31'h0, pend8}, {31'h0, e.pend});
          check(e.name, "mis",  {31'h0, mis8}, {31'h0, e.mis});
        end else begin
          check(e.name, "pc",   pc, e.pc);
          check(e.name, "ce",   {31'h0, ce}, {31'h0, e.ce});
          check(e.name, "pend", {31'h0, pend}, {31'h0, e.pend});
          check(e.name, "mis",  {31'h0, mis}, {31'h0, e.mis});
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input bit is8, input string name,
                      input logic r, input logic s, input logic b, input logic [31:0] btgt,
                      input logic f, input logic [31:0] ftgt,
                      input logic [31:0] epc, input logic ece, input logic epend);
    exp_t e;
    @(negedge clk);
    if (is8) begin
      rst8 = r; stall8 = s; bf8 = b; bt8 = btgt[7:0]; fl8 = f; ft8 = ftgt[7:0];
    end else begin
      rst = r; stall = s; bf = b; bt = btgt; fl = f; ft = ftgt;
    end
    e.is8  = is8;
    e.pc   = epc;
    e.ce   = ece;
    e.pend = epend;
    e.mis  = ece & (epc[1:0] != 2'b00);
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    // T1 reset and release
    for (int i = 0; i < 3; i++) step(0, "t1_rst", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    step(0, "t1_first", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    step(0, "t1_p4",    0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    step(0, "t1_p8",    0, 0, 0, 0, 0, 0, 32'h8, 1, 0);
    // T2 stall holds
    step(0, "t2_pc",    0, 0, 0, 0, 0, 0, 32'hC, 1, 0);
    step(0, "t2_pc",    0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    for (int i = 0; i < 3; i++) step(0, "t2_stall", 0, 1, 0, 0, 0, 0, 32'h10, 1, 0);
    step(0, "t2_rel",   0, 0, 0, 0, 0, 0, 32'h14, 1, 0);
    step(0, "t2_seq",   0, 0, 0, 0, 0, 0, 32'h18, 1, 0);
    step(0, "t2_seq",   0, 0, 0, 0, 0, 0, 32'h1C, 1, 0);
    step(0, "t2_seq",   0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
    // T3 branch during stall is buffered
    step(0, "t3_buf",   0, 1, 1, 32'h100, 0, 0, 32'h20, 1, 1);
    step(0, "t3_rel",   0, 0, 0, 0, 0, 0, 32'h100, 1, 0);
    step(0, "t3_seq",   0, 0, 0, 0, 0, 0, 32'h104, 1, 0);
    // T4 later stalled branch overwrites; live branch beats buffered one
    step(0, "t4_b1",    0, 1, 1, 32'h100, 0, 0, 32'h104, 1, 1);
    step(0, "t4_b2",    0, 1, 1, 32'h200, 0, 0, 32'h104, 1, 1);
    step(0, "t4_hold",  0, 1, 0, 0, 0, 0, 32'h104, 1, 1);
    step(0, "t4_rel",   0, 0, 0, 0, 0, 0, 32'h200, 1, 0);
    step(0, "t4_b3",    0, 1, 1, 32'h300, 0, 0, 32'h200, 1, 1);
    step(0, "t4_live",  0, 0, 1, 32'h400, 0, 0, 32'h400, 1, 0);
    step(0, "t4_seq",   0, 0, 0, 0, 0, 0, 32'h404, 1, 0);
    // T5 flush overrides stall, branch and buffer; reset clears the buffer
    step(0, "t5_buf",   0, 1, 1, 32'h500, 0, 0, 32'h404, 1, 1);
    step(0, "t5_flush", 0, 1, 1, 32'h600, 1, 32'h180, 32'h180, 1, 0);
    step(0, "t5_seq",   0, 0, 0, 0, 0, 0, 32'h184, 1, 0);
    step(0, "t5_buf2",  0, 1, 1, 32'h700, 0, 0, 32'h184, 1, 1);
    step(0, "t5_rst",   1, 1, 1, 32'h800, 0, 0, 32'h0, 0, 0);
    step(0, "t5_rel",   0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    step(0, "t5_seq",   0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    step(0, "t5_fbr",   0, 0, 1, 32'h900, 1, 32'h183, 32'h183, 1, 0);
    step(0, "t5_mis",   0, 0, 0, 0, 0, 0, 32'h187, 1, 0);
    step(0, "t5_align", 0, 0, 1, 32'h188, 0, 0, 32'h188, 1, 0);
    // T6 8-bit wrap and misaligned branch
    step(1, "t6_rst",   1, 0, 0, 0, 0, 0, 32'hF0, 0, 0);
    step(1, "t6_first", 0, 0, 0, 0, 0, 0, 32'hF0, 1, 0);
    step(1, "t6_seq",   0, 0, 0, 0, 0, 0, 32'hF4, 1, 0);
    step(1, "t6_seq",   0, 0, 0, 0, 0, 0, 32'hF8, 1, 0);
    step(1, "t6_seq",   0, 0, 0, 0, 0, 0, 32'hFC, 1, 0);
    step(1, "t6_wrap",  0, 0, 0, 0, 0, 0, 32'h00, 1, 0);
    step(1, "t6_seq",   0, 0, 0, 0, 0, 0, 32'h04, 1, 0);
    step(1, "t6_mis",   0, 0, 1, 32'h02, 0, 0, 32'h02, 1, 0);
    step(1, "t6_mis2",  0, 0, 0, 0, 0, 0, 32'h06, 1, 0);
    step(1, "t6_align", 0, 0, 1, 32'h08, 0, 0, 32'h08, 1, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
